mc_datapath: RTL and testbench

//   Multicycle MIPS datapath: the consumer of the control unit's strobes and the producer of Op/Funct.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/mc_alu.sv | 29 ++
 rtl/mc_datapath.sv | 110 +++++++++++
 tb/tb_mc_datapath.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Encodings shared between the multicycle MIPS datapath and its control FSM:
// ALU operation codes, ALU B-source select values and the primary opcodes.
package mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multicycle datapath: add/sub/and/or/signed slt.
// Unused operation codes produce zero.
module mc_alu
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, 32x32 register file and ALU.
// Optional DATAPATH_DEBUG_EN adds a third register-file read port and a PC view.
module mc_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCWrite,
  input  logic            Branch,
  input  logic            PCSrc,
  input  logic [2:0]      ALUControl,
  input  logic [1:0]      ALUSrcB,
  input  logic            ALUSrcA,
  input  logic            RegWrite,
  input  logic            lorD,
  input  logic            MemWrite,
  input  logic            IRWrite,
  input  logic            RegDst,
  input  logic            MemtoReg,
  output logic [5:0]      Op,
  output logic [5:0]      Funct,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  input  logic [XLEN-1:0] mem_rdata
`ifdef DATAPATH_DEBUG_EN
  ,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [XLEN-1:0] dbg_pc
`endif
);

  logic [XLEN-1:0] pc, ir, mdr, a, b, alu_out;
  logic [XLEN-1:0] rf [32];
  logic [XLEN-1:0] rd1, rd2, src_a, src_b, sign_imm, alu_result, wdata;
  logic [4:0]      wreg;
  logic            zero, pc_en;

  assign sign_imm = sign_ext16(ir[15:0]);
  assign rd1      = (ir[25:21] == 5'd0) ? '0 : rf[ir[25:21]];
  assign rd2      = (ir[20:16] == 5'd0) ? '0 : rf[ir[20:16]];
  assign wreg     = RegDst ? ir[15:11] : ir[20:16];
  assign wdata    = MemtoReg ? mdr : alu_out;

  assign src_a = ALUSrcA ? a : pc;

  always_comb begin
    src_b = b;
    case (ALUSrcB)
      SRCB_B:     src_b = b;
      SRCB_FOUR:  src_b = 32'd4;
      SRCB_IMM:   src_b = sign_imm;
      SRCB_IMMSH: src_b = {sign_imm[XLEN-3:0], 2'b00};
      default:    src_b = b;
    endcase
  end

  mc_alu #(.XLEN(XLEN)) u_alu (
    .a           (src_a),
    .b           (src_b),
    .alu_control (ALUControl),
    .result      (alu_result),
    .zero        (zero)
  );

  assign pc_en = PCWrite | (Branch & zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      ir      <= '0;
      mdr     <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
    end else begin
      mdr     <= mem_rdata;
      a       <= rd1;
      b       <= rd2;
      alu_out <= alu_result;
      if (IRWrite) ir <= mem_rdata;
      if (pc_en)   pc <= PCSrc ? alu_out : alu_result;
    end
  end

  // A/B above read the pre-edge contents, so a same-edge write is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (RegWrite && (wreg != 5'd0)) begin
      rf[wreg] <= wdata;
    end
  end

  assign Op        = ir[31:26];
  assign Funct     = ir[5:0];
  assign mem_addr  = lorD ? alu_out : pc;
  assign mem_wdata = b;
  assign mem_we    = MemWrite;

`ifdef DATAPATH_DEBUG_EN
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : rf[dbg_raddr];
  assign dbg_pc    = pc;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: architectural model of the datapath state, checked every
// negedge, plus directed instruction sequences with hand-computed expectations.
module tb_mc_datapath;

  logic        clk, rst_n;
  logic        PCWrite, Branch, PCSrc, ALUSrcA, RegWrite, lorD, MemWrite, IRWrite, RegDst, MemtoReg;
  logic [2:0]  ALUControl;
  logic [1:0]  ALUSrcB;
  logic [5:0]  Op, Funct;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
`ifdef DATAPATH_DEBUG_EN
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata, dbg_pc;
`endif

  mc_datapath #(.RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc),
    .ALUControl(ALUControl), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .lorD(lorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .Op(Op), .Funct(Funct), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
`ifdef DATAPATH_DEBUG_EN
    , .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .dbg_pc(dbg_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Architectural state of the model
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
  logic [31:0] m_rf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b111:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic model_reset();
    m_pc = 32'h100; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
  endtask

  // One clock edge: model next state from the pre-edge inputs, then advance.
  task automatic tick();
    logic [31:0] imm, sa, sb, res, n_pc, n_ir, n_a, n_b, n_mdr, wd;
    logic [4:0]  wr;
    logic        we;
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    sa  = ALUSrcA ? m_a : m_pc;
    case (ALUSrcB)
      2'd0:    sb = m_b;
      2'd1:    sb = 32'd4;
      2'd2:    sb = imm;
      default: sb = imm * 4;
    endcase
    res   = alu_ref(ALUControl, sa, sb);
    n_pc  = (PCWrite || (Branch && res == 0)) ? (PCSrc ? m_aluout : res) : m_pc;
    n_ir  = IRWrite ? mem_rdata : m_ir;
    n_a   = m_rf[m_ir[25:21]];
    n_b   = m_rf[m_ir[20:16]];
    n_mdr = mem_rdata;
    wr    = RegDst ? m_ir[15:11] : m_ir[20:16];
    wd    = MemtoReg ? m_mdr : m_aluout;
    we    = RegWrite;
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_pc = n_pc; m_ir = n_ir; m_a = n_a; m_b = n_b; m_mdr = n_mdr; m_aluout = res;
      if (we && wr != 0) m_rf[wr] = wd;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("op",        {26'd0, Op},    {26'd0, m_ir[31:26]});
      chk("funct",     {26'd0, Funct}, {26'd0, m_ir[5:0]});
      chk("mem_addr",  mem_addr,       lorD ? m_aluout : m_pc);
      chk("mem_wdata", mem_wdata,      m_b);
      chk("mem_we",    {31'd0, mem_we}, {31'd0, MemWrite});
`ifdef DATAPATH_DEBUG_EN
      chk("dbg_pc",    dbg_pc,         m_pc);
      chk("dbg_rdata", dbg_rdata,      m_rf[dbg_raddr]);
`endif
    end
  end

  task automatic clr();
    PCWrite = 0; Branch = 0; PCSrc = 0; ALUControl = 3'b010; ALUSrcB = 2'd0; ALUSrcA = 0;
    RegWrite = 0; lorD = 0; MemWrite = 0; IRWrite = 0; RegDst = 0; MemtoReg = 0;
  endtask

  task automatic rand_ctl();
    {PCWrite, Branch, PCSrc, ALUSrcA, RegWrite, lorD, MemWrite, IRWrite, RegDst, MemtoReg} = 10'($urandom);
    ALUControl = 3'($urandom);
    ALUSrcB    = 2'($urandom);
    mem_rdata  = $urandom;
`ifdef DATAPATH_DEBUG_EN
    dbg_raddr  = 5'($urandom);
`endif
  endtask

  task automatic do_reset();
    #2;
    MemWrite = 1;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_pc",    mem_addr,  32'h100);
    chk("rst_op",    {26'd0, Op}, 32'd0);
    chk("rst_funct", {26'd0, Funct}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_we1",   {31'd0, mem_we}, 32'd1);
    MemWrite = 0;
    #1;
    chk("rst_we0",   {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string name);
    clr(); mem_rdata = itype(6'd0, 5'd0, r, 16'd0); IRWrite = 1; tick();
    clr(); tick();
    chk(name, mem_wdata, exp);
  endtask

  task automatic fetch(input logic [31:0] w);
    clr(); mem_rdata = w; IRWrite = 1; ALUSrcB = 2'd1; PCWrite = 1; tick();
    clr(); ALUSrcB = 2'd3; tick();
  endtask

  task automatic run_addi(input logic [31:0] w);
    fetch(w);
    clr(); ALUSrcA = 1; ALUSrcB = 2'd2; tick();
    clr(); RegWrite = 1; tick();
  endtask

  task automatic run_r(input logic [31:0] w, input logic [2:0] ctl);
    fetch(w);
    clr(); ALUSrcA = 1; ALUControl = ctl; tick();
    clr(); RegDst = 1; RegWrite = 1; tick();
  endtask

  task automatic run_beq(input logic [31:0] w);
    fetch(w);
    clr(); ALUSrcA = 1; ALUControl = 3'b110; Branch = 1; PCSrc = 1; tick();
    clr();
  endtask

  initial begin
    rst_n = 0; mem_rdata = 0; clr();
`ifdef DATAPATH_DEBUG_EN
    dbg_raddr = 0;
`endif
    model_reset();
    chk_en = 1;
    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 400; i++) begin rand_ctl(); tick(); end

    clr();
    do_reset();
    peek(5'd8, 32'd0, "rst_rf8");
    peek(5'd31, 32'd0, "rst_rf31");

    fetch(itype(6'h08, 5'd0, 5'd8, 16'd5));
    chk("fetch_op", {26'd0, Op}, 32'h08);
    chk("fetch_pc", mem_addr, 32'h104);
    clr(); ALUSrcA = 1; ALUSrcB = 2'd2; tick();
    clr(); RegWrite = 1; tick();
    run_addi(itype(6'h08, 5'd0, 5'd9, 16'd7));
    peek(5'd8, 32'd5, "addi_r8");
    peek(5'd9, 32'd7, "addi_r9");

    run_beq(itype(6'h04, 5'd0, 5'd0, 16'd3));
    chk("beq_taken", mem_addr, 32'h118);
    run_beq(itype(6'h04, 5'd8, 5'd9, 16'd3));
    chk("beq_not_taken", mem_addr, 32'h11C);
    tick();
    chk("pc_hold", mem_addr, 32'h11C);

    run_r(rtype(5'd8, 5'd9, 5'd10, 6'h22), 3'b110);
    peek(5'd10, 32'hFFFF_FFFE, "sub");
    run_r(rtype(5'd8, 5'd9, 5'd10, 6'h2a), 3'b111);
    peek(5'd10, 32'd1, "slt");
    run_r(rtype(5'd8, 5'd9, 5'd10, 6'h25), 3'b001);
    peek(5'd10, 32'd7, "or");
    run_r(rtype(5'd8, 5'd9, 5'd10, 6'h24), 3'b000);
    peek(5'd10, 32'd5, "and");
    run_addi(itype(6'h08, 5'd0, 5'd11, 16'hFFFF));
    run_addi(itype(6'h08, 5'd0, 5'd12, 16'd1));
    run_r(rtype(5'd11, 5'd12, 5'd13, 6'h2a), 3'b111);
    peek(5'd13, 32'd1, "slt_signed");

    fetch(itype(6'h2b, 5'd0, 5'd9, 16'h40));
    clr(); ALUSrcA = 1; ALUSrcB = 2'd2; tick();
    clr(); lorD = 1; MemWrite = 1; #1;
    chk("sw_addr", mem_addr, 32'h40);
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_wdata", mem_wdata, 32'd7);
    tick();
    fetch(itype(6'h23, 5'd0, 5'd14, 16'h40));
    clr(); ALUSrcA = 1; ALUSrcB = 2'd2; tick();
    clr(); lorD = 1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("lw_addr", mem_addr, 32'h40);
    tick();
    clr(); MemtoReg = 1; RegWrite = 1; mem_rdata = 32'h1234_5678; tick();
    peek(5'd14, 32'hDEAD_BEEF, "lw_data");

    run_addi(itype(6'h08, 5'd0, 5'd0, 16'd5));
    peek(5'd0, 32'd0, "r0_write");

    fetch(itype(6'h08, 5'd8, 5'd8, 16'd1));
    clr(); ALUSrcA = 1; ALUSrcB = 2'd2; tick();
    clr(); RegWrite = 1; tick();
    clr(); ALUSrcA = 1; ALUSrcB = 2'd1; tick();
    clr(); lorD = 1; #1;
    chk("no_bypass", mem_addr, 32'd9);
    tick();
    peek(5'd8, 32'd6, "r8_written");

    for (int i = 0; i < 300; i++) begin rand_ctl(); tick(); end

    fetch(itype(6'h08, 5'd0, 5'd9, 16'hFFFC));
    clr(); ALUSrcA = 1; ALUSrcB = 2'd2; PCWrite = 1; tick();
    clr(); #1;
    chk("pc_fffc", mem_addr, 32'hFFFF_FFFC);
    ALUSrcB = 2'd1; PCWrite = 1; tick();
    clr(); #1;
    chk("pc_wrap", mem_addr, 32'h0000_0000);
    tick();

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
